// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: register addresses, region bounds and the
// OAM DMA state encoding.
package nes_bus_pkg;

    localparam logic [15:0] DMA_REG_ADDR_C  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_C = 16'h2004;

    localparam logic [15:0] RAM_BASE_C      = 16'h0000;
    localparam logic [15:0] RAM_END_C       = 16'h1FFF;
    localparam logic [15:0] PPU_REG_BASE_C  = 16'h2000;
    localparam logic [15:0] PPU_REG_END_C   = 16'h3FFF;
    localparam logic [15:0] APU_IO_BASE_C   = 16'h4000;
    localparam logic [15:0] APU_IO_END_C    = 16'h401F;
    localparam logic [15:0] CART_BASE_C     = 16'h4020;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to the DMA register halts the CPU and copies one
// page through the bus into the PPU OAM data port, one read/write pair per byte.
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_C,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_C,
    parameter int unsigned NUM_BYTES     = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw_n,
    input  logic [7:0]  bus_data_in,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_out,
    output logic        dma_rw_n,
    output logic        dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    dma_state_t r_state;
    dma_state_t w_next;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_latch;
    logic       r_parity;
    logic       r_done;
    logic       w_trigger;
    logic       w_last;

    assign w_trigger = (r_state == IDLE) && !cpu_rw_n && (cpu_addr == DMA_REG_ADDR);
    assign w_last    = (r_idx == LAST_IDX);

    // Parity runs freely so HALT can tell whether an alignment cycle is needed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_parity <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_parity <= ~r_parity;
            r_done   <= (r_state == WRITE) && w_last;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_page  <= '0;
            r_idx   <= '0;
            r_latch <= '0;
        end else begin
            if (w_trigger) begin
                r_page <= cpu_data_out;
                r_idx  <= '0;
            end
            if (r_state == READ)
                r_latch <= bus_data_in;
            if ((r_state == WRITE) && !w_last)
                r_idx <= r_idx + 8'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_trigger) w_next = HALT;
            HALT:    w_next = r_parity ? ALIGN : READ;
            ALIGN:   w_next = READ;
            READ:    w_next = WRITE;
            WRITE:   w_next = w_last ? IDLE : READ;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_halt     = 1'b0;
        dma_active   = 1'b0;
        dma_addr     = '0;
        dma_data_out = '0;
        dma_rw_n     = 1'b1;
        case (r_state)
            HALT, ALIGN: cpu_halt = 1'b1;
            READ: begin
                cpu_halt   = 1'b1;
                dma_active = 1'b1;
                dma_addr   = {r_page, r_idx};
            end
            WRITE: begin
                cpu_halt     = 1'b1;
                dma_active   = 1'b1;
                dma_rw_n     = 1'b0;
                dma_addr     = OAM_DATA_ADDR;
                dma_data_out = r_latch;
            end
            default: ;
        endcase
    end

    assign dma_done = r_done;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: parity alignment, page wrap, ignored
// triggers, mid-transfer reset and back-to-back transfers.
module tb_oam_dma;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rw_n;
    logic [7:0]  bus_data_in;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_rw_n;
    logic        dma_done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        tb_par;

    oam_dma #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004),
        .NUM_BYTES    (256)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .cpu_addr    (cpu_addr),
        .cpu_data_out(cpu_data_out),
        .cpu_rw_n    (cpu_rw_n),
        .bus_data_in (bus_data_in),
        .cpu_halt    (cpu_halt),
        .dma_active  (dma_active),
        .dma_addr    (dma_addr),
        .dma_data_out(dma_data_out),
        .dma_rw_n    (dma_rw_n),
        .dma_done    (dma_done)
    );

    always #5 CLK = ~CLK;

    // Memory image: any byte at offset i within a page holds i ^ $5A.
    assign bus_data_in = dma_active ? (dma_addr[7:0] ^ 8'h5A) : 8'hEE;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) tb_par <= 1'b0;
        else       tb_par <= ~tb_par;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_halt"}, 32'(cpu_halt), 32'd0);
        chk({tag, "_active"}, 32'(dma_active), 32'd0);
        chk({tag, "_addr"}, 32'(dma_addr), 32'd0);
        chk({tag, "_data"}, 32'(dma_data_out), 32'd0);
        chk({tag, "_rw_n"}, 32'(dma_rw_n), 32'd1);
        chk({tag, "_done"}, 32'(dma_done), 32'd0);
    endtask

    // mode: 0 = even HALT parity, 1 = odd, 2 = trigger immediately.
    task automatic run_xfer(input logic [7:0] page, input int mode,
                            input int inj_byte, input int rst_byte);
        int unsigned halt_cnt = 0, pre_cnt = 0, rd_cnt = 0, wr_cnt = 0;
        int unsigned bad_rd = 0, bad_wr = 0, low_hits = 0, done_cnt = 0, bad_done = 0;
        logic [15:0] first_rd = '1, last_rd = '0;
        bit exp_align, fin = 0, aborted = 0, prev_halt = 1;
        if (mode < 2)
            while (tb_par != !mode[0]) tick();
        exp_align = ~tb_par;
        cpu_addr = 16'h4014; cpu_rw_n = 1'b0; cpu_data_out = page;
        tick();
        for (int c = 0; c < 700 && !fin; c++) begin
            cpu_addr = 16'h0000; cpu_rw_n = 1'b1; cpu_data_out = 8'h00;
            if (cpu_halt) halt_cnt++;
            if (cpu_halt && !dma_active) pre_cnt++;
            if (dma_active && dma_rw_n) begin
                if (rd_cnt == 0) first_rd = dma_addr;
                last_rd = dma_addr;
                if (dma_addr != {page, 8'(rd_cnt)}) bad_rd++;
                if (dma_addr[15:8] == 8'h00) low_hits++;
                if (int'(rd_cnt) == inj_byte) begin
                    cpu_addr = 16'h4014; cpu_rw_n = 1'b0; cpu_data_out = 8'h07;
                end
                if (int'(rd_cnt) == rst_byte) begin
                    #2 RESET = 1'b1;
                    #1 chk_idle_outputs("rst_async");
                    #3 RESET = 1'b0;
                    aborted = 1;
                    fin = 1;
                end
                rd_cnt++;
            end else if (dma_active) begin
                if (dma_addr != 16'h2004 || dma_data_out != (8'(wr_cnt) ^ 8'h5A)) bad_wr++;
                wr_cnt++;
            end
            if (dma_done) begin
                done_cnt++;
                if (!prev_halt || cpu_halt) bad_done++;
                fin = 1;
            end
            prev_halt = cpu_halt;
            if (!fin) tick();
        end
        if (!fin) begin
            chk("timeout", 32'd0, 32'd1);
            return;
        end
        if (aborted) begin
            for (int k = 0; k < 6; k++) begin
                tick();
                if (dma_done) done_cnt++;
                if (cpu_halt) halt_cnt++;
            end
            chk("rst_no_done", done_cnt, 0);
            chk("rst_reads", rd_cnt, 32'(rst_byte + 1));
            chk_idle_outputs("rst_after");
            return;
        end
        chk("halt_cycles", halt_cnt, 513 + 32'(exp_align));
        chk("pre_cycles", pre_cnt, 1 + 32'(exp_align));
        chk("rd_count", rd_cnt, 256);
        chk("wr_count", wr_cnt, 256);
        chk("rd_addr_seq", bad_rd, 0);
        chk("wr_data_seq", bad_wr, 0);
        chk("first_rd", 32'(first_rd), 32'({page, 8'h00}));
        chk("last_rd", 32'(last_rd), 32'({page, 8'hFF}));
        if (page != 8'h00) chk("low_page_hits", low_hits, 0);
        chk("done_pulses", done_cnt, 1);
        chk("done_at_halt_fall", bad_done, 0);
        tick();
        chk("done_one_cycle", 32'(dma_done), 32'd0);
        chk("post_halt", 32'(cpu_halt), 32'd0);
    endtask

    initial begin
        int unsigned h;
        RESET = 1'b1;
        cpu_addr = 16'h0000; cpu_rw_n = 1'b1; cpu_data_out = 8'h00;
        #12;
        chk_idle_outputs("reset");
        RESET = 1'b0;
        tick();

        cpu_addr = 16'h4014; cpu_rw_n = 1'b1; cpu_data_out = 8'h03;
        h = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (cpu_halt || dma_active) h++;
        end
        chk("read_no_trigger", h, 0);
        cpu_addr = 16'h0000;
        tick();

        run_xfer(8'h02, 0, -1, -1);
        tick();
        run_xfer(8'h02, 1, -1, -1);
        tick();
        run_xfer(8'h02, 0, 50, -1);
        tick();
        run_xfer(8'hFF, 2, -1, -1);
        tick();
        run_xfer(8'h02, 2, -1, 100);
        run_xfer(8'h02, 2, -1, -1);
        run_xfer(8'h02, 2, -1, -1);
        run_xfer(8'h03, 2, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1, "global timeout");
    end

endmodule
